// File: rtl/aludec_mdu.sv
// ALU control decoder with a one-entry valid/ready output stage, plus an
// iterative multiply/divide sequencer that owns the architectural HI/LO registers.
module aludec_mdu #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alucontrol,
  output logic [WIDTH-1:0] md_data,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic                 outValid_q, outValid_d;
  logic [5:0]           aluCtrl_q, aluCtrl_d;
  logic [WIDTH-1:0]     mdData_q, mdData_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
  logic                 divZero_q, divZero_d;

  logic [5:0]           op, funct, aluDec;
  logic                 accept, isMul, isDivOp, launch, signedOp, rsNeg, rtNeg;
  logic [WIDTH-1:0]     rsMag, rtMag, quot, rem, divDiff;
  logic [WIDTH:0]       mulSum, divShift;
  logic                 divFits;
  logic [2*WIDTH-1:0]   mulNext, divNext, prodFix;
  logic                 unusedInstr;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unusedInstr = ^instr[25:6];

  assign in_ready = (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    aluDec = 6'h00;
    if (op == 6'h00)                        aluDec = funct;
    else if (op >= 6'h08 && op <= 6'h0E)    aluDec = op + 6'h18;
    else if (op == 6'h14 || op == 6'h16 || op == 6'h17) aluDec = op - 6'h10;
    else if (op >= 6'h18 && op <= 6'h1D)    aluDec = op + 6'h10;
  end

  assign isMul    = (op == 6'h00) && (funct == 6'h18 || funct == 6'h19);
  assign isDivOp  = DIV_EN && (op == 6'h00) && (funct == 6'h1A || funct == 6'h1B);
  assign launch   = accept && (isMul || isDivOp);
  assign signedOp = !funct[0];
  assign rsNeg    = signedOp && rs_val[WIDTH-1];
  assign rtNeg    = signedOp && rt_val[WIDTH-1];
  assign rsMag    = rsNeg ? -rs_val : rs_val;
  assign rtMag    = rtNeg ? -rt_val : rt_val;

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign mulSum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mulNext = {mulSum, prod_q[WIDTH-1:1]};

  // Restoring step: the partial remainder never exceeds the divisor, so WIDTH bits hold it.
  assign rem      = prod_q[2*WIDTH-1:WIDTH];
  assign quot     = prod_q[WIDTH-1:0];
  assign divShift = {rem, prod_q[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opnd_q};
  assign divDiff  = divShift[WIDTH-1:0] - opnd_q;
  assign divNext  = {divFits ? divDiff : divShift[WIDTH-1:0], prod_q[WIDTH-2:0], divFits};
  assign prodFix  = negRes_q ? -prod_q : prod_q;

  always_comb begin
    state_d    = state_q;
    outValid_d = outValid_q;
    aluCtrl_d  = aluCtrl_q;
    mdData_d   = mdData_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    isDiv_d    = isDiv_q;
    negRes_d   = negRes_q;
    negRem_d   = negRem_q;
    divZero_d  = divZero_q;

    if (accept) begin
      outValid_d = 1'b1;
      aluCtrl_d  = aluDec;
      mdData_d   = '0;
      if (op == 6'h00 && funct == 6'h10) mdData_d = hi_q;
      if (op == 6'h00 && funct == 6'h12) mdData_d = lo_q;
      if (op == 6'h00 && funct == 6'h11) hi_d = rs_val;
      if (op == 6'h00 && funct == 6'h13) lo_d = rs_val;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = RUN;
          cnt_d     = '0;
          isDiv_d   = isDivOp;
          negRes_d  = rsNeg ^ rtNeg;
          negRem_d  = rsNeg;
          divZero_d = (rt_val == '0);
          if (isDivOp) begin
            prod_d = {{WIDTH{1'b0}}, rsMag};
            opnd_d = rtMag;
          end else begin
            prod_d = {{WIDTH{1'b0}}, rtMag};
            opnd_d = rsMag;
          end
        end
      end
      RUN: begin
        prod_d = isDiv_q ? divNext : mulNext;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (isDiv_q) begin
          lo_d = divZero_q ? '1 : (negRes_q ? -quot : quot);
          hi_d = negRem_q ? -rem : rem;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      aluCtrl_q  <= '0;
      mdData_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      isDiv_q    <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      divZero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      aluCtrl_q  <= aluCtrl_d;
      mdData_q   <= mdData_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      isDiv_q    <= isDiv_d;
      negRes_q   <= negRes_d;
      negRem_q   <= negRem_d;
      divZero_q  <= divZero_d;
    end
  end

  assign out_valid  = outValid_q;
  assign alucontrol = aluCtrl_q;
  assign md_data    = mdData_q;
  assign md_busy    = (state_q != IDLE);
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_aludec_mdu.sv
// Bench for aludec_mdu: an arithmetic reference model checked every cycle against the
// WIDTH=32 instance, plus directed literal checks on WIDTH=32, WIDTH=8 and DIV_EN=0 instances.
module tb_aludec_mdu;

  localparam int W = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inValid, outReady, checkEn;
  logic [31:0] instr, rsVal, rtVal;

  logic        inReady, outValid, mdBusy;
  logic [5:0]  aluCtrl;
  logic [31:0] mdData, hiO, loO;

  logic        inReady8, outValid8, mdBusy8;
  logic [5:0]  aluCtrl8;
  logic [7:0]  mdData8, hi8, lo8;

  logic        inReadyN, outValidN, mdBusyN;
  logic [5:0]  aluCtrlN;
  logic [31:0] mdDataN, hiN, loN;

  int nCompared = 0;
  int nMismatched = 0;

  aludec_mdu #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .instr(instr),
    .rs_val(rsVal), .rt_val(rtVal), .out_valid(outValid), .out_ready(outReady),
    .alucontrol(aluCtrl), .md_data(mdData), .md_busy(mdBusy), .hi(hiO), .lo(loO));

  aludec_mdu #(.WIDTH(8), .DIV_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady8), .instr(instr),
    .rs_val(rsVal[7:0]), .rt_val(rtVal[7:0]), .out_valid(outValid8), .out_ready(outReady),
    .alucontrol(aluCtrl8), .md_data(mdData8), .md_busy(mdBusy8), .hi(hi8), .lo(lo8));

  aludec_mdu #(.WIDTH(32), .DIV_EN(1'b0)) dutNd (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyN), .instr(instr),
    .rs_val(rsVal), .rt_val(rtVal), .out_valid(outValidN), .out_ready(outReady),
    .alucontrol(aluCtrlN), .md_data(mdDataN), .md_busy(mdBusyN), .hi(hiN), .lo(loN));

  // Reference model state for the WIDTH=32 instance.
  logic        mOutValid, mAcc;
  logic [5:0]  mAlu;
  logic [31:0] mMd, mHi, mLo;
  logic [63:0] pRes;
  int          mBusyCnt;

  function automatic logic [5:0] decodeModel(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op == 0) return ins[5:0];
    if (op >= 8 && op <= 14) return 6'(op + 24);
    if (op == 20) return 6'd4;
    if (op == 22) return 6'd6;
    if (op == 23) return 6'd7;
    if (op >= 24 && op <= 29) return 6'(op + 16);
    return 6'd0;
  endfunction

  function automatic logic [63:0] mdResult(input logic [5:0] f, input logic [31:0] rs,
                                           input logic [31:0] rt);
    logic signed [63:0] sp;
    logic [63:0] up;
    int a, b;
    case (f)
      6'h18: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        return sp;
      end
      6'h19: begin
        up = {32'h0, rs} * {32'h0, rt};
        return up;
      end
      6'h1A: begin
        a = $signed(rs);
        b = $signed(rt);
        if (b == 0) return {rs, 32'hFFFFFFFF};
        if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(a % b), 32'(a / b)};
      end
      default: begin
        if (rt == 32'h0) return {rs, 32'hFFFFFFFF};
        return {rs % rt, rs / rt};
      end
    endcase
  endfunction

  assign mAcc = inValid && (mBusyCnt == 0) && (!mOutValid || outReady);

  always @(posedge clk) begin
    if (rst) begin
      mOutValid <= 1'b0;
      mAlu      <= '0;
      mMd       <= '0;
      mHi       <= '0;
      mLo       <= '0;
      pRes      <= '0;
      mBusyCnt  <= 0;
    end else begin
      if (mBusyCnt != 0) begin
        mBusyCnt <= mBusyCnt - 1;
        if (mBusyCnt == 1) begin
          mHi <= pRes[63:32];
          mLo <= pRes[31:0];
        end
      end
      if (mAcc) begin
        mOutValid <= 1'b1;
        mAlu      <= decodeModel(instr);
        mMd       <= (instr[31:26] == 6'h0 && instr[5:0] == 6'h10) ? mHi :
                     (instr[31:26] == 6'h0 && instr[5:0] == 6'h12) ? mLo : 32'h0;
        if (instr[31:26] == 6'h0 && instr[5:0] == 6'h11) mHi <= rsVal;
        if (instr[31:26] == 6'h0 && instr[5:0] == 6'h13) mLo <= rsVal;
        if (instr[31:26] == 6'h0 && instr[5:0] >= 6'h18 && instr[5:0] <= 6'h1B) begin
          pRes     <= mdResult(instr[5:0], rsVal, rtVal);
          mBusyCnt <= W + 1;
        end
      end else if (outReady) begin
        mOutValid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model in_ready", inReady, (mBusyCnt == 0) && (!mOutValid || outReady));
      checkOutput("model out_valid", outValid, mOutValid);
      checkOutput("model md_busy", mdBusy, mBusyCnt != 0);
      checkOutput("model hi", hiO, mHi);
      checkOutput("model lo", loO, mLo);
      if (mOutValid) begin
        checkOutput("model alucontrol", aluCtrl, mAlu);
        checkOutput("model md_data", mdData, mMd);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                               input logic [31:0] rt, input logic ordy);
    inValid  = v;
    instr    = ins;
    rsVal    = rs;
    rtVal    = rt;
    outReady = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rInstr(input logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  function automatic logic [31:0] iInstr(input logic [5:0] o);
    return {o, 26'h0};
  endfunction

  task automatic runMd(input string name, input logic [5:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int n;
    applyStimulus(1'b1, rInstr(f), rs, rt, 1'b1);
    n = 0;
    while (mdBusy === 1'b1 && n < 200) begin
      n++;
      idle(1);
    end
    checkOutput({name, " busy cycles"}, n, W + 1);
    checkOutput({name, " hi"}, hiO, expHi);
    checkOutput({name, " lo"}, loO, expLo);
    checkOutput({name, " model hi"}, mHi, expHi);
    checkOutput({name, " model lo"}, mLo, expLo);
  endtask

  logic [31:0] sweepIns[6];
  logic [5:0]  sweepAlu[6];

  initial begin
    int n, n8;
    logic got;
    rst = 1'b1; inValid = 1'b0; instr = '0; rsVal = '0; rtVal = '0;
    outReady = 1'b1; checkEn = 1'b0;
    sweepIns = '{iInstr(6'h08), iInstr(6'h0E), iInstr(6'h14), iInstr(6'h1D),
                 rInstr(6'h2A), iInstr(6'h02)};
    sweepAlu = '{6'h20, 6'h26, 6'h04, 6'h2D, 6'h2A, 6'h00};

    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset alucontrol", aluCtrl, 0);
    checkOutput("reset md_data", mdData, 0);
    checkOutput("reset hi", hiO, 0);
    checkOutput("reset lo", loO, 0);
    checkOutput("reset md_busy", mdBusy, 0);
    checkOutput("reset in_ready", inReady, 1);
    rst = 1'b0;

    $display("[TB] decode sweep");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, sweepIns[i], 32'h0, 32'h0, 1'b1);
      checkOutput("decode out_valid", outValid, 1);
      checkOutput("decode alucontrol", aluCtrl, sweepAlu[i]);
    end
    idle(1);
    checkOutput("decode out_valid drop", outValid, 0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, iInstr(6'h08), 32'h0, 32'h0, 1'b0);
    checkOutput("bp first alucontrol", aluCtrl, 6'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, iInstr(6'h0A), 32'h0, 32'h0, 1'b0);
      checkOutput("bp in_ready", inReady, 0);
      checkOutput("bp out_valid held", outValid, 1);
      checkOutput("bp alucontrol held", aluCtrl, 6'h20);
    end
    applyStimulus(1'b1, iInstr(6'h0A), 32'h0, 32'h0, 1'b1);
    checkOutput("bp release out_valid", outValid, 1);
    checkOutput("bp release alucontrol", aluCtrl, 6'h22);
    idle(1);

    $display("[TB] multiply and divide");
    runMd("mult -2*3", 6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runMd("multu", 6'h19, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    runMd("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runMd("divu 7/0", 6'h1B, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    runMd("div min/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    $display("[TB] move to/from");
    applyStimulus(1'b1, rInstr(6'h11), 32'h1234, 32'h0, 1'b1);
    applyStimulus(1'b1, rInstr(6'h10), 32'h0, 32'h0, 1'b1);
    checkOutput("mfhi md_data", mdData, 32'h1234);
    idle(1);

    applyStimulus(1'b1, rInstr(6'h19), 32'd5, 32'd6, 1'b1);
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      applyStimulus(1'b1, rInstr(6'h12), 32'h0, 32'h0, 1'b1);
      n++;
      if (outValid === 1'b1 && aluCtrl === 6'h12) got = 1'b1;
    end
    checkOutput("mflo wait cycles", n, W + 2);
    checkOutput("mflo md_data", mdData, 32'd30);
    idle(1);

    $display("[TB] reset mid-multiply");
    applyStimulus(1'b1, rInstr(6'h11), 32'hABCD, 32'h0, 1'b1);
    applyStimulus(1'b1, rInstr(6'h18), 32'hFFFFFFFE, 32'd3, 1'b1);
    idle(10);
    rst = 1'b1;
    idle(1);
    checkOutput("rst md_busy", mdBusy, 0);
    checkOutput("rst hi", hiO, 0);
    checkOutput("rst lo", loO, 0);
    checkOutput("rst out_valid", outValid, 0);
    checkOutput("rst in_ready", inReady, 1);
    rst = 1'b0;

    $display("[TB] WIDTH=8 multiply");
    applyStimulus(1'b1, rInstr(6'h18), 32'hFFFFFFFE, 32'd3, 1'b1);
    n = 0;
    n8 = 0;
    while ((mdBusy === 1'b1 || mdBusy8 === 1'b1) && n < 200) begin
      n++;
      if (mdBusy8 === 1'b1) n8++;
      idle(1);
    end
    checkOutput("w8 busy cycles", n8, 9);
    checkOutput("w8 hi", hi8, 8'hFF);
    checkOutput("w8 lo", lo8, 8'hFA);
    checkOutput("nodiv mult lo", loN, 32'hFFFFFFFA);

    $display("[TB] DIV_EN=0 divide");
    applyStimulus(1'b1, rInstr(6'h1A), 32'hFFFFFFF9, 32'd2, 1'b1);
    checkOutput("nodiv md_busy", mdBusyN, 0);
    checkOutput("nodiv alucontrol", aluCtrlN, 6'h1A);
    n = 0;
    while (mdBusy === 1'b1 && n < 200) begin
      n++;
      idle(1);
    end
    checkOutput("nodiv md_busy later", mdBusyN, 0);
    checkOutput("nodiv hi kept", hiN, 32'hFFFFFFFF);
    checkOutput("nodiv lo kept", loN, 32'hFFFFFFFA);
    checkOutput("div-en lo", loO, 32'hFFFFFFFD);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/aludec_mdu.md
Name: aludec_mdu

Overview:
- Next-generation ALU decoder for the MIPS core. Decodes a 32-bit instruction into the 6-bit ALU control code and delivers it through a one-entry registered valid/ready stage.
- Adds an iterative multiply/divide sequencer with architectural HI/LO registers, parametrised in datapath width.
- Sits between the instruction register and the ALU/writeback stage.
- Asserts md_busy to stall issue while a multiply or divide is in flight.

Parameters:
- WIDTH, 32, datapath width of rs_val/rt_val/hi/lo/md_data; legal values are 4 and above.
- DIV_EN, 1, 1 = div/divu run on the sequencer; 0 = div/divu decode only, HI/LO unchanged, no busy.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  instruction offered
- in_ready  output  1  block can accept this cycle
- instr  input  32  instruction word
- rs_val  input  WIDTH  rs operand
- rt_val  input  WIDTH  rt operand
- out_valid  output  1  alucontrol/md_data valid
- out_ready  input  1  downstream accepts output
- alucontrol  output  6  decoded ALU control
- md_data  output  WIDTH  HI (mfhi) or LO (mflo), else 0
- md_busy  output  1  multiply/divide in progress
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high (clk, rst).
  - Accept = in_valid && in_ready.
  - in_ready = !md_busy && (!out_valid || out_ready). It is combinational and is 1 after reset.
- Reset values:
  - out_valid=0, alucontrol=0, md_data=0, hi=0, lo=0, md_busy=0.
  - The sequencer is in IDLE and the counter is 0.
- Reset mid-operation abandons the operation. HI/LO are cleared, not written with a partial result.
- Decode (op = instr[31:26], funct = instr[5:0]):
  - op 0x00 -> funct.
  - op 0x08..0x0E -> 0x20..0x26 respectively.
  - op 0x14 -> 0x04; op 0x16 -> 0x06; op 0x17 -> 0x07.
  - op 0x18..0x1D -> 0x28..0x2D respectively.
  - Any other op -> 0x00.
- Output stage:
  - On accept, alucontrol and md_data are registered and out_valid=1 on the next cycle.
  - out_valid clears when out_ready=1 and there is no new accept.
  - While out_valid && !out_ready, alucontrol and md_data hold stable.
  - Latency is 1 cycle for every instruction.
- md_data:
  - funct 0x10 (mfhi, op 0) -> current hi.
  - funct 0x12 (mflo, op 0) -> current lo.
  - Otherwise 0.
- Move-to instructions:
  - funct 0x11 (mthi): hi<=rs_val at the accept edge.
  - funct 0x13 (mtlo): lo<=rs_val at the accept edge.
- Multiply/divide launch (op 0, funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu; div/divu only when DIV_EN=1):
  - At the accept edge T, capture operand magnitudes (absolute values for signed ops) and the result signs.
  - The decode output issues normally at T+1 with alucontrol=funct.
- Sequencer FSM:
  - IDLE -> RUN on a launch accept.
  - RUN takes exactly WIDTH cycles, one bit per cycle, counter 0..WIDTH-1.
  - RUN -> FIX after the last bit.
  - FIX applies sign correction, writes hi/lo at edge T+WIDTH+1, then returns to IDLE.
  - md_busy is registered: 1 from T+1 through the FIX cycle (WIDTH+1 cycles); 0 from T+WIDTH+1.
  - A new instruction can be accepted in the first cycle md_busy=0.
- Multiply:
  - Shift-add on magnitudes; 2*WIDTH-bit product, hi=upper half, lo=lower half.
  - mult negates the product when the operand signs differ.
- Divide:
  - Restoring division on magnitudes; lo=quotient, hi=remainder.
  - div: quotient negated when signs differ; remainder takes the sign of rs.
- Boundary results:
  - Divide by zero, div or divu: lo=all ones, hi=rs_val unchanged, full WIDTH+1 latency.
  - div of MIN by -1: lo=MIN, hi=0.
- Other instructions never touch hi/lo.
- While busy, no instruction is accepted, including mfhi/mflo/mthi/mtlo.

Test Plan:
- Reset, then decode sweep: op 0x08 -> alucontrol 0x20; op 0x0E -> 0x26; op 0x14 -> 0x04; op 0x1D -> 0x2D; op 0x00 funct 0x2A -> 0x2A; op 0x02 -> 0x00. Each has out_valid exactly one cycle after accept.
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles. in_ready=0 and alucontrol stays stable; releasing out_ready=1 in the same cycle as a new in_valid accepts back-to-back with no bubble.
- WIDTH=32 mult with rs=0xFFFFFFFE (-2), rt=3: md_busy high for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu give hi=0x00000002, lo=0xFFFFFFFA.
- div with rs=-7, rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rs=7, rt=0: lo=0xFFFFFFFF, hi=7. div with rs=0x80000000, rt=0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi 0x1234, then mfhi: md_data=0x1234. An mflo offered while busy is not accepted until md_busy falls, then returns the new lo.
- Assert rst at RUN cycle 10 of a mult: next cycle md_busy=0, hi=lo=0, out_valid=0, in_ready=1. Repeat the multiply scenario with WIDTH=8: md_busy high for 9 cycles. With DIV_EN=0, div leaves hi/lo unchanged and md_busy stays 0.
